// File: rtl/mean_doubler.sv
// Sequential 2*mean of a 2^NUM_QUBIT-lane amplitude vector, one lane per cycle,
// emitted together with the captured vector so the downstream subtractor gets a matched pair.
module mean_doubler #(
    parameter int NUM_QUBIT  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_WIDTH*(2**NUM_QUBIT)-1:0]      in_vec,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [DATA_WIDTH-1:0]                     mean_out,
    output logic [DATA_WIDTH*(2**NUM_QUBIT)-1:0]      vec_out,
    output logic                                      out_valid,
    input  logic                                      out_ready
);

    localparam int NUM_B_INPUT = 2 ** NUM_QUBIT;
    localparam int ACC_W       = DATA_WIDTH + NUM_QUBIT;
    localparam int IDX_W       = (NUM_QUBIT > 0) ? NUM_QUBIT : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_B_INPUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // state is kept as a named register so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0] acc;
    logic        [IDX_W-1:0] idx;
    logic   [DATA_WIDTH-1:0] lanes [NUM_B_INPUT];
    logic   [DATA_WIDTH-1:0] lane;
    logic signed [ACC_W-1:0] lane_ext;
    logic signed [ACC_W-1:0] sum_next;
    logic signed   [ACC_W:0] dbl;
    logic signed   [ACC_W:0] shifted;

    for (genvar j = 0; j < NUM_B_INPUT; j++) begin : g_lanes
        assign lanes[j] = vec_out[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH];
    end

    // Lanes are read from the captured copy, so in_vec is free to change after acceptance.
    always_comb begin
        lane     = lanes[idx];
        lane_ext = ACC_W'($signed(lane));
        sum_next = acc + lane_ext;
        dbl      = {sum_next, 1'b0};
        shifted  = dbl >>> NUM_QUBIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake: a transfer happens only on an edge where valid and ready are both high;
    // valid on either side is ignored while the matching ready is low, and vice versa.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ACCUM;
            end
            ACCUM: begin
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out  <= '0;
            mean_out <= '0;
            acc      <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_out <= in_vec;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                ACCUM: begin
                    acc <= sum_next;
                    idx <= idx + 1'b1;
                    // Floor rounding comes from the arithmetic shift; the result wraps to DATA_WIDTH.
                    if (idx == LAST_IDX) mean_out <= shifted[DATA_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mean_doubler.md
Name: mean_doubler

Overview:
- Producer-side companion of the per-lane subtractor in the Grover diffusion datapath.
- Takes one 2^NUM_QUBIT-lane amplitude vector and accumulates the lanes sequentially, one lane per cycle.
- Outputs the scalar 2*mean together with a registered copy of the same vector, so the subtractor's A and B are always a matched pair.
- Valid/ready handshake on both sides. Two's-complement integer arithmetic.

Parameters:
- NUM_QUBIT, 4, number of qubits; lane count NUM_B_INPUT = 2**NUM_QUBIT.
- DATA_WIDTH, 32, width of each amplitude lane and of mean_out.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_vec  input  DATA_WIDTH*NUM_B_INPUT  amplitude vector; lane j = in_vec[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH]
- in_valid  input  1  in_vec valid
- in_ready  output  1  block can accept a vector
- mean_out  output  DATA_WIDTH  2*mean of the captured vector (feeds the subtractor A)
- vec_out  output  DATA_WIDTH*NUM_B_INPUT  registered copy of the captured vector (feeds the subtractor B)
- out_valid  output  1  mean_out and vec_out valid
- out_ready  input  1  downstream consumed the result

Behaviour:
- Reset: the single clock is clk. Reset rst is synchronous and active-high. When rst=1 at an edge:
  - state=IDLE, in_ready=1, out_valid=0
  - mean_out=0, vec_out=0, accumulator=0, lane index=0
  - rst overrides everything, including mid-ACCUM or DONE; any partial result is discarded.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid=1, capture in_vec into vec_out, clear the accumulator and lane index, and go to ACCUM.
  - ACCUM: in_ready=0, out_valid=0. Each edge adds sign-extended lane[idx] of the captured vector to the accumulator and increments idx. Lanes are summed from vec_out, never from in_vec, so in_vec may change freely after acceptance.
    - On the edge that adds lane NUM_B_INPUT-1, the same edge also loads mean_out, sets out_valid=1 and goes to DONE.
  - DONE: out_valid=1, in_ready=0. mean_out and vec_out stay stable while out_ready=0. On an edge with out_ready=1, clear out_valid, set in_ready=1 and go to IDLE.
- Latency and throughput:
  - Acceptance edge E0; out_valid is first high after edge E(NUM_B_INPUT), i.e. 16 cycles for the defaults.
  - Minimum initiation interval is NUM_B_INPUT+2 cycles: accept, 16 adds, one DONE cycle with out_ready already high, return to IDLE.
  - No bypass: a new vector cannot be accepted in the same cycle as the DONE handoff.
- Arithmetic:
  - Accumulator width is DATA_WIDTH+NUM_QUBIT and is signed, so it cannot overflow.
  - mean_out = (sum <<< 1) >>> NUM_QUBIT, arithmetic shift, floor rounding toward -inf. The result is truncated to the low DATA_WIDTH bits (wraps modulo 2^DATA_WIDTH).
  - With NUM_QUBIT=0 the lane count is 1, and mean_out = 2*lane0 truncated.
- Handshake rules:
  - in_valid may be held high while in_ready=0; the block ignores it.
  - out_ready may be high while out_valid=0; the block ignores it.
  - A transfer occurs only when valid and ready are both high at an edge.

Test Plan:
- All 16 lanes = 1, out_ready=1 → in_ready drops for the accumulation; out_valid rises 16 cycles after acceptance; mean_out=2; vec_out equals input.
- Lanes j=0..15 equal to j → sum 120, mean_out = 240>>>4 = 15.
- All lanes = -3 (0xFFFFFFFD) → sum -48, mean_out = -6 (0xFFFFFFFA). Single-lane check: lane0=-1, rest 0 → mean_out = -1 (floor of -2/16). Same check with lane0=+1 → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → mean_out/vec_out stable, in_ready=0, a second in_valid pulse ignored. Raise out_ready → in_ready=1 the next cycle; the second vector is then accepted and processed correctly.
- Input change after accept: change in_vec every cycle during ACCUM → result reflects only the vector captured at E0.
- Reset mid-ACCUM (after 7 adds) → next cycle in_ready=1, out_valid=0, mean_out=0. A fresh vector of all 2s afterward yields mean_out=4 with no residue from the aborted sum.
